shift_arbiter: RTL and testbench
================================

Name: shift_arbiter

Overview:
- Shares one registered rotate/shift datapath between two requesters using round-robin arbitration.
- Each requester presents an operand, a shift amount and an operation under a valid/ready handshake.
- The result comes back on a single valid/ready response channel, tagged with the requester ID.
- Sits between control FSMs and the shared shifter. Throughput is one operation per clock when the response side is not stalled.

Parameters:
- WIDTH, 8, operand/result width in bits; must be a power of 2 and at least 2.
- AMT_W, $clog2(WIDTH), width of the shift-amount field (derived; not overridden).

Ports:
- clk  input  1  system clock; all state updates on the rising edge.
- rst_n  input  1  synchronous, active-low reset.
- req_valid  input  2  per-requester request valid; bit i belongs to requester i.
- req_ready  output  2  per-requester accept; one-hot or zero.
- req_data  input  2*WIDTH  operands; requester i uses slice [i*WIDTH +: WIDTH].
- req_amt  input  2*AMT_W  shift amounts; requester i uses slice [i*AMT_W +: AMT_W].
- req_op  input  4  operations; requester i uses [2i+1:2i]. 00 rotate-left, 01 rotate-right, 10 logical shift-left, 11 logical shift-right.
- rsp_valid  output  1  result register holds a valid result.
- rsp_ready  input  1  downstream accepts the result.
- rsp_data  output  WIDTH  shifted/rotated result.
- rsp_id  output  1  index of the requester that issued this result.

Behaviour:
- Reset (rst_n low at a clk edge):
  - rsp_valid=0, rsp_data=0, rsp_id=0.
  - Round-robin pointer last_grant=1, so requester 0 has priority first.
  - req_ready=0 while rst_n is low.
  - Reset mid-operation discards any held result; no response is emitted for it.
- Output slot:
  - can_accept = !rsp_valid || rsp_ready.
- Arbitration (combinational each cycle):
  - If only one req_valid bit is set, that requester is granted.
  - If both are set, the requester other than last_grant is granted.
  - If none are set, there is no grant.
  - req_ready[i] = grant[i] && can_accept && rst_n.
  - req_ready must not depend on the same requester's data, amt or op.
- Transfer: a request fires when req_valid[i] && req_ready[i].
- On fire:
  - rsp_data <= f(op, data, amt); rsp_id <= i; rsp_valid <= 1; last_grant <= i.
  - Latency is one cycle: fire at edge N makes the result visible after edge N.
- No fire, but rsp_valid && rsp_ready: rsp_valid <= 0; rsp_data and rsp_id hold their values.
- Simultaneous response drain and new fire in the same cycle: the new result replaces the old one and rsp_valid stays 1 (back-to-back, no bubble).
- Stall (rsp_valid && !rsp_ready):
  - req_ready=0 on both requesters.
  - rsp_data and rsp_id are stable until the response is consumed.
  - last_grant is unchanged.
- Fairness:
  - With both requesters continuously valid and rsp_ready=1, grants strictly alternate 0,1,0,1,...
  - No requester waits more than one grant while the other is served.
- Arithmetic (amt is taken modulo WIDTH by its width):
  - Rotate-left: (d << amt) | (d >> (WIDTH-amt)). amt=0 returns d unchanged; there is no full-width shift hazard.
  - Rotate-right: (d >> amt) | (d << (WIDTH-amt)). amt=0 returns d.
  - Logical shifts fill vacated bits with 0. amt=WIDTH-1 leaves one surviving bit.
- Requesters must keep data, amt and op stable while valid is asserted and ready is low. The block does not sample them except on fire.
- Dropping valid without a fire is tolerated and has no effect.

Decomposition:
- Package shift_pkg:
  - typedef enum logic [1:0] shift_op_e {OP_ROTL, OP_ROTR, OP_SHL, OP_SHR}.
  - Localparam NUM_REQ=2.
- Sub-module shift_unit (combinational):
  - Inputs: data, amt, op. Output: result.
  - Written as a log2(WIDTH)-stage mux barrel with stage k shifting by 2^k.
- Top level: arbiter, pointer, output register and handshake logic.

Test Plan:
- Reset: hold rst_n=0 for 3 cycles with both req_valid=1 -> req_ready=00, rsp_valid=0, rsp_data=0. First grant after release goes to requester 0.
- Single op: requester 0 sends data=8'b1011_0011, amt=3, op=ROTL, rsp_ready=1 -> next cycle rsp_valid=1, rsp_data=8'b1001_1101, rsp_id=0.
- All ops with d=8'hB3, amt=0 and amt=7:
  - amt=0: ROTL=B3, ROTR=B3, SHL=B3, SHR=B3.
  - amt=7: ROTL=D9, ROTR=67, SHL=80, SHR=01.
- Contention: both requesters valid for 6 cycles, rsp_ready=1 -> rsp_id sequence 0,1,0,1,0,1 with a response on every cycle.
- Backpressure: hold rsp_ready=0 for 4 cycles with a result pending -> req_ready=00, and rsp_data and rsp_id are unchanged for those 4 cycles. On release, drain and new accept happen in the same cycle.
- Reset mid-stall: rst_n=0 while rsp_valid=1 -> rsp_valid=0 after the edge; the held result is never observed.

Source files
------------

// File: rtl/shift_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
package shift_pkg;

   localparam int NUM_REQ = 2;

   typedef enum logic [1:0] {
      OP_ROTL = 2'b00,
      OP_ROTR = 2'b01,
      OP_SHL  = 2'b10,
      OP_SHR  = 2'b11
   } shift_op_e;

endpackage

// File: rtl/shift_unit.sv
// Combinational mux barrel shifter/rotator; stage k moves the word by 2^k
// positions when amt_i[k] is set.
module shift_unit
   import shift_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic [WIDTH-1:0] data_i,
   input  logic [AMT_W-1:0] amt_i,
   input  shift_op_e        op_i,
   output logic [WIDTH-1:0] result_o
);

   logic [WIDTH-1:0] stage_s;

   // Barrel stages; every stage amount is below WIDTH, so no full-width shift occurs
   always_comb begin
      stage_s = data_i;
      for (int k = 0; k < AMT_W; k++) begin
         if (amt_i[k]) begin
            case (op_i)
               OP_ROTL: stage_s = (stage_s << (1 << k)) | (stage_s >> (WIDTH - (1 << k)));
               OP_ROTR: stage_s = (stage_s >> (1 << k)) | (stage_s << (WIDTH - (1 << k)));
               OP_SHL:  stage_s = stage_s << (1 << k);
               OP_SHR:  stage_s = stage_s >> (1 << k);
               default: stage_s = stage_s;
            endcase
         end else begin
            stage_s = stage_s;
         end
      end
   end

   assign result_o = stage_s;

endmodule

// File: rtl/shift_arbiter.sv
// Round-robin arbiter sharing one registered shift/rotate datapath between
// two requesters, with a single tagged valid/ready response channel.
module shift_arbiter
   import shift_pkg::*;
#(
   parameter  int WIDTH = 8,
   localparam int AMT_W = $clog2(WIDTH)
) (
   input  logic                     clk,
   input  logic                     rst_n,
   input  logic [NUM_REQ-1:0]       req_valid,
   output logic [NUM_REQ-1:0]       req_ready,
   input  logic [NUM_REQ*WIDTH-1:0] req_data,
   input  logic [NUM_REQ*AMT_W-1:0] req_amt,
   input  logic [2*NUM_REQ-1:0]     req_op,
   output logic                     rsp_valid,
   input  logic                     rsp_ready,
   output logic [WIDTH-1:0]         rsp_data,
   output logic                     rsp_id
);

   logic               rsp_valid_q, rsp_valid_d;
   logic [WIDTH-1:0]   rsp_data_q, rsp_data_d;
   logic               rsp_id_q, rsp_id_d;
   logic               last_grant_q, last_grant_d;

   logic               can_accept_s;
   logic [NUM_REQ-1:0] grant_s;
   logic               fire_s;
   logic               sel_id_s;
   logic [WIDTH-1:0]   sel_data_s;
   logic [AMT_W-1:0]   sel_amt_s;
   shift_op_e          sel_op_s;
   logic [WIDTH-1:0]   result_s;

   assign can_accept_s = !rsp_valid_q || rsp_ready;

   // Round-robin grant: on contention the requester not served last wins
   always_comb begin
      grant_s = 2'b00;
      case (req_valid)
         2'b01:   grant_s = 2'b01;
         2'b10:   grant_s = 2'b10;
         2'b11:   grant_s = last_grant_q ? 2'b01 : 2'b10;
         default: grant_s = 2'b00;
      endcase
   end

   assign req_ready  = grant_s & {NUM_REQ{can_accept_s & rst_n}};
   assign fire_s     = |(req_valid & req_ready);
   assign sel_id_s   = req_ready[1];
   assign sel_data_s = sel_id_s ? req_data[WIDTH +: WIDTH] : req_data[0 +: WIDTH];
   assign sel_amt_s  = sel_id_s ? req_amt[AMT_W +: AMT_W] : req_amt[0 +: AMT_W];
   assign sel_op_s   = shift_op_e'(sel_id_s ? req_op[3:2] : req_op[1:0]);

   shift_unit #(.WIDTH(WIDTH)) u_shift_unit (
      .data_i   (sel_data_s),
      .amt_i    (sel_amt_s),
      .op_i     (sel_op_s),
      .result_o (result_s)
   );

   // Output slot next state: a new fire overwrites, a drain alone clears valid
   always_comb begin
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      rsp_id_d     = rsp_id_q;
      last_grant_d = last_grant_q;
      if (fire_s) begin
         rsp_valid_d  = 1'b1;
         rsp_data_d   = result_s;
         rsp_id_d     = sel_id_s;
         last_grant_d = sel_id_s;
      end else if (rsp_valid_q && rsp_ready) begin
         rsp_valid_d = 1'b0;
      end else begin
         rsp_valid_d = rsp_valid_q;
      end
   end

   // State registers with synchronous active-low reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         rsp_valid_q  <= 1'b0;
         rsp_data_q   <= '0;
         rsp_id_q     <= 1'b0;
         last_grant_q <= 1'b1;
      end else begin
         rsp_valid_q  <= rsp_valid_d;
         rsp_data_q   <= rsp_data_d;
         rsp_id_q     <= rsp_id_d;
         last_grant_q <= last_grant_d;
      end
   end

   assign rsp_valid = rsp_valid_q;
   assign rsp_data  = rsp_data_q;
   assign rsp_id    = rsp_id_q;

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed-vector bench for shift_arbiter with hand-computed expectations.
module tb_shift_arbiter;
   import shift_pkg::*;

   localparam int WIDTH = 8;
   localparam int AMT_W = 3;

   logic                   clk = 1'b0;
   logic                   rst_n;
   logic [1:0]             req_valid;
   logic [1:0]             req_ready;
   logic [2*WIDTH-1:0]     req_data;
   logic [2*AMT_W-1:0]     req_amt;
   logic [3:0]             req_op;
   logic                   rsp_valid;
   logic                   rsp_ready;
   logic [WIDTH-1:0]       rsp_data;
   logic                   rsp_id;

   int n_tests = 0;
   int n_fail  = 0;

   localparam logic [7:0] TD [10] = '{8'hB3, 8'hB3, 8'hB3, 8'hB3, 8'hB3, 8'hB3, 8'hB3, 8'hB3, 8'h81, 8'h81};
   localparam logic [2:0] TA [10] = '{3'd0, 3'd0, 3'd0, 3'd0, 3'd7, 3'd7, 3'd7, 3'd7, 3'd1, 3'd1};
   localparam logic [1:0] TO [10] = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1, 2'd2, 2'd3, 2'd3, 2'd1};
   localparam logic [7:0] TE [10] = '{8'hB3, 8'hB3, 8'hB3, 8'hB3, 8'hD9, 8'h67, 8'h80, 8'h01, 8'h40, 8'hC0};

   shift_arbiter #(.WIDTH(WIDTH)) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid),
      .req_ready (req_ready),
      .req_data  (req_data),
      .req_amt   (req_amt),
      .req_op    (req_op),
      .rsp_valid (rsp_valid),
      .rsp_ready (rsp_ready),
      .rsp_data  (rsp_data),
      .rsp_id    (rsp_id)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_tests++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic set_req(input int i, input logic [7:0] d, input logic [2:0] a, input logic [1:0] op);
      req_data[i*WIDTH +: WIDTH] = d;
      req_amt[i*AMT_W +: AMT_W]  = a;
      req_op[2*i +: 2]           = op;
   endtask

   initial begin
      rst_n     = 1'b0;
      rsp_ready = 1'b1;
      req_valid = 2'b11;
      req_data  = '0;
      req_amt   = '0;
      req_op    = '0;
      set_req(0, 8'b1011_0011, 3'd3, 2'(OP_ROTL));
      set_req(1, 8'h55, 3'd1, 2'(OP_SHL));

      // reset held with both requesters valid
      for (int c = 0; c < 3; c++) begin
         tick();
         check("rst_ready", 32'(req_ready), 32'h0);
         check("rst_valid", 32'(rsp_valid), 32'h0);
         check("rst_data",  32'(rsp_data),  32'h0);
         check("rst_id",    32'(rsp_id),    32'h0);
      end

      // first grant after release is requester 0; rotl 3 of B3 is 9D
      rst_n = 1'b1;
      #1;
      check("first_grant", 32'(req_ready), 32'h1);
      tick();
      check("single_valid", 32'(rsp_valid), 32'h1);
      check("single_data",  32'(rsp_data),  32'h9D);
      check("single_id",    32'(rsp_id),    32'h0);
      req_valid = 2'b00;
      tick();
      check("drain_valid", 32'(rsp_valid), 32'h0);
      check("drain_data_hold", 32'(rsp_data), 32'h9D);

      // every op at boundary amounts, alternating the issuing requester
      for (int j = 0; j < 10; j++) begin
         set_req(j % 2, TD[j], TA[j], TO[j]);
         req_valid = (j % 2 == 0) ? 2'b01 : 2'b10;
         tick();
         check("op_valid", 32'(rsp_valid), 32'h1);
         check("op_data",  32'(rsp_data),  32'(TE[j]));
         check("op_id",    32'(rsp_id),    32'(j % 2));
      end

      // contention: strict alternation starting at 0, one response per cycle
      set_req(0, 8'h0F, 3'd1, 2'(OP_ROTL));
      set_req(1, 8'hF0, 3'd2, 2'(OP_SHR));
      req_valid = 2'b11;
      for (int k = 0; k < 6; k++) begin
         tick();
         check("rr_valid", 32'(rsp_valid), 32'h1);
         check("rr_id",    32'(rsp_id),    32'(k % 2));
         check("rr_data",  32'(rsp_data),  (k % 2 == 1) ? 32'h3C : 32'h1E);
      end

      // backpressure: result held, no grants
      rsp_ready = 1'b0;
      #1;
      check("bp_ready0", 32'(req_ready), 32'h0);
      for (int k = 0; k < 4; k++) begin
         tick();
         check("bp_ready", 32'(req_ready), 32'h0);
         check("bp_valid", 32'(rsp_valid), 32'h1);
         check("bp_data",  32'(rsp_data),  32'h3C);
         check("bp_id",    32'(rsp_id),    32'h1);
      end
      rsp_ready = 1'b1;
      #1;
      check("bp_release_ready", 32'(req_ready), 32'h1);
      tick();
      check("bp_swap_valid", 32'(rsp_valid), 32'h1);
      check("bp_swap_id",    32'(rsp_id),    32'h0);
      check("bp_swap_data",  32'(rsp_data),  32'h1E);

      // reset during a stall discards the held result
      req_valid = 2'b00;
      rsp_ready = 1'b0;
      tick();
      check("stall_valid", 32'(rsp_valid), 32'h1);
      rst_n = 1'b0;
      tick();
      check("mid_rst_valid", 32'(rsp_valid), 32'h0);
      check("mid_rst_data",  32'(rsp_data),  32'h0);
      rst_n     = 1'b1;
      rsp_ready = 1'b1;
      tick();
      check("post_rst_valid", 32'(rsp_valid), 32'h0);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
